aes_ctr_sequencer: RTL and testbench

- CTR-mode front/back end for the AES-128 core wrapper: drives the core's init/next pulses and presents the counter block (nonce || counter).
- Accepts 128-bit plaintext blocks on a valid/ready stream, XORs each with the core result and emits ciphertext on an output valid/ready stream.
- Sits directly around the core: upstream of its block/key/init/next inputs, downstream of its ready/result outputs.

---
 rtl/aes_ctr_sequencer.sv | 141 ++++++++++++++
 tb/tb_aes_ctr_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer: CTR-mode sequencer around an AES-128 core wrapper.
// Holds key/nonce/counter stable for the core and keeps one block in flight.
module aes_ctr_sequencer #(
    parameter int CTR_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_load,
    input  logic [127:0]           key_in,
    input  logic                   ctr_load,
    input  logic [127-CTR_WIDTH:0] nonce_in,
    input  logic [CTR_WIDTH-1:0]   ctr_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           out_data,
    output logic                   core_init,
    output logic                   core_next,
    output logic [127:0]           core_key,
    output logic [127:0]           core_block,
    input  logic                   core_ready,
    input  logic [127:0]           core_result,
    output logic                   key_valid,
    output logic                   busy,
    output logic                   ctr_wrap
);
    typedef enum logic [2:0] {IDLE, KEY_START, KEY_WAIT, ENC_START, ENC_WAIT, OUTPUT} state_t;

    state_t                 state_q, state_d;
    logic [127:0]           key_q, key_d;
    logic [127-CTR_WIDTH:0] nonce_q, nonce_d;
    logic [CTR_WIDTH-1:0]   ctr_q, ctr_d;
    logic [127:0]           data_q, data_d;
    logic [127:0]           out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   core_init_q, core_init_d;
    logic                   core_next_q, core_next_d;
    logic                   key_valid_q, key_valid_d;
    logic                   busy_q, busy_d;
    logic                   ctr_wrap_q, ctr_wrap_d;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        nonce_d     = nonce_q;
        ctr_d       = ctr_q;
        data_d      = data_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        key_valid_d = key_valid_q;
        ctr_wrap_d  = ctr_wrap_q;
        in_ready    = state_q == IDLE && !key_load && !ctr_load && in_valid && key_valid_q;
        case (state_q)
            IDLE: begin
                if (key_load) begin
                    key_d       = key_in;
                    key_valid_d = 1'b0;
                    ctr_wrap_d  = 1'b0;
                    state_d     = KEY_START;
                end else if (ctr_load) begin
                    nonce_d    = nonce_in;
                    ctr_d      = ctr_in;
                    ctr_wrap_d = 1'b0;
                end else if (in_ready) begin
                    data_d  = in_data;
                    state_d = ENC_START;
                end
            end
            KEY_START: state_d = KEY_WAIT;
            KEY_WAIT: begin
                if (core_ready) begin
                    key_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            ENC_START: state_d = ENC_WAIT;
            ENC_WAIT: begin
                if (core_ready) begin
                    out_data_d  = data_q ^ core_result;
                    out_valid_d = 1'b1;
                    ctr_d       = ctr_q + CTR_WIDTH'(1);
                    ctr_wrap_d  = ctr_wrap_q | (&ctr_q);
                    state_d     = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Pulses and busy are registered off the next state so they align with it.
        core_init_d = state_d == KEY_START;
        core_next_d = state_d == ENC_START;
        busy_d      = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            key_q       <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
            data_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            core_init_q <= 1'b0;
            core_next_q <= 1'b0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ctr_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            nonce_q     <= nonce_d;
            ctr_q       <= ctr_d;
            data_q      <= data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            core_init_q <= core_init_d;
            core_next_q <= core_next_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            ctr_wrap_q  <= ctr_wrap_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign core_init  = core_init_q;
    assign core_next  = core_next_q;
    assign core_key   = key_q;
    assign core_block = {nonce_q, ctr_q};
    assign key_valid  = key_valid_q;
    assign busy       = busy_q;
    assign ctr_wrap   = ctr_wrap_q;
endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// tb_aes_ctr_sequencer: randomized bench with a behavioural CTR model and a stand-in AES core.
module tb_aes_ctr_sequencer;
    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] B2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] KS1 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] KS2 = 128'h362b7c3c6773516318a077d7fc5073ae;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT1 = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CT2 = 128'h9806f66b7970fdff8617187bb9fffdff;

    logic clk = 0, reset = 1;
    logic key_load = 0, ctr_load = 0, in_valid = 0, out_ready = 0;
    logic [127:0] key_in = '0, in_data = '0;
    logic [63:0] nonce_in = '0, ctr_in = '0;
    logic in_ready, out_valid, core_init, core_next, key_valid, busy, ctr_wrap;
    logic [127:0] out_data, core_key, core_block;
    logic core_ready = 1;
    logic [127:0] core_result = '0, pend_ks = '0;
    int cnt = 0;

    logic [127:0] key_m = '0, exp_m = '0;
    logic [63:0] nonce_m = '0, ctr_m = '0;
    logic kv_m = 0, wrap_m = 0, pend_m = 0;
    int init_cnt = 0;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    aes_ctr_sequencer #(.CTR_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in),
        .ctr_load(ctr_load), .nonce_in(nonce_in), .ctr_in(ctr_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_init(core_init), .core_next(core_next), .core_key(core_key),
        .core_block(core_block), .core_ready(core_ready), .core_result(core_result),
        .key_valid(key_valid), .busy(busy), .ctr_wrap(ctr_wrap)
    );

    // Stand-in for AES-128: the two SP800-38A blocks are exact, anything else is a keyed mix.
    function automatic logic [127:0] ks_fn(input logic [127:0] k, input logic [127:0] b);
        if (k == K0 && b == B1) return KS1;
        if (k == K0 && b == B2) return KS2;
        return k ^ {b[63:0], b[127:64]} ^ {b[100:0], b[127:101]} ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    always @(posedge clk) begin
        if (core_init || core_next) begin
            cnt        <= $urandom_range(1, 5);
            core_ready <= 1'b0;
            pend_ks    <= ks_fn(core_key, core_block);
        end else if (cnt == 1) begin
            cnt         <= 0;
            core_ready  <= 1'b1;
            core_result <= pend_ks;
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end
    end

    task automatic checkv(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic checkb(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic check_i(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout", name);
    endtask

    always @(negedge clk) begin
        if (core_init) init_cnt++;
        checkb("in_ready_gate", in_ready & (busy | out_valid | ~kv_m), 1'b0);
        checkb("key_valid", key_valid, kv_m);
        checkv("core_key", core_key, key_m);
        if (out_valid) begin
            checkv("out_data", out_data, exp_m);
            checkb("out_expected", pend_m, 1'b1);
        end
        if (core_next) checkv("next_block", core_block, {nonce_m, ctr_m});
        if (!busy) begin
            checkv("idle_block", core_block, {nonce_m, ctr_m});
            checkb("ctr_wrap", ctr_wrap, wrap_m);
            checkb("idle_out_valid", out_valid, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy && !out_valid) return;
        end
        timeout(name);
    endtask

    task automatic key_task(input logic [127:0] k, input logic also_ctr);
        int n0;
        n0 = init_cnt;
        key_load = 1; key_in = k; ctr_load = also_ctr;
        nonce_in = ~nonce_m; ctr_in = ~ctr_m;
        tick();
        key_load = 0; ctr_load = 0;
        key_m = k; kv_m = 0; wrap_m = 0;
        wait_idle("key_done");
        kv_m = 1;
        check_i("init_pulses", init_cnt - n0, 1);
    endtask

    task automatic ctr_task(input logic [63:0] n, input logic [63:0] c);
        ctr_load = 1; nonce_in = n; ctr_in = c;
        tick();
        ctr_load = 0;
        nonce_m = n; ctr_m = c; wrap_m = 0;
    endtask

    task automatic enc_task(input logic [127:0] pt, input int hold, input logic kl_mid, output logic [127:0] got);
        int n0;
        got = '0;
        in_valid = 1; in_data = pt;
        #1;
        checkb("in_ready_offer", in_ready, 1'b1);
        exp_m = pt ^ ks_fn(key_m, {nonce_m, ctr_m});
        pend_m = 1;
        tick();
        in_valid = 0;
        n0 = init_cnt;
        if (kl_mid) begin
            tick();
            key_load = 1; key_in = ~key_m;
            tick();
            key_load = 0;
        end
        for (int i = 0; i < 100 && !out_valid; i++) tick();
        if (!out_valid) begin
            timeout("out_valid");
            pend_m = 0;
            return;
        end
        got = out_data;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1; in_data = ~pt;
            tick();
        end
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
        if (&ctr_m) wrap_m = 1;
        ctr_m = ctr_m + 64'd1;
        pend_m = 0;
        checkv("handshake_idle", 128'({busy, out_valid}), 128'd0);
        if (kl_mid) check_i("ignored_key_load", init_cnt - n0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got;
        logic [63:0] sv, nn;
        int r;
        repeat (2) tick();
        checkv("rst_flags", 128'({in_ready, out_valid, core_init, core_next, key_valid, ctr_wrap, busy}), 128'd0);
        checkv("rst_out_data", out_data, 128'd0);
        checkv("rst_core_block", core_block, 128'd0);
        reset = 0;
        tick();

        in_valid = 1; in_data = {4{$urandom}};
        repeat (3) begin
            tick();
            checkb("no_key_in_ready", in_ready, 1'b0);
        end
        in_valid = 0;

        key_task(K0, 1'b0);
        ctr_task(64'hf0f1f2f3f4f5f6f7, 64'hf8f9fafbfcfdfeff);
        enc_task(PT1, 0, 1'b0, got);
        checkv("f51_block1", got, CT1);
        checkv("block2_ctr", core_block, B2);
        enc_task(PT2, 0, 1'b0, got);
        checkv("f51_block2", got, CT2);

        enc_task({4{$urandom}}, 10, 1'b0, got);

        nn = {$urandom, $urandom};
        ctr_task(nn, 64'hffffffffffffffff);
        enc_task({4{$urandom}}, 1, 1'b0, got);
        checkv("wrap_block", core_block, {nn, 64'h0});
        checkb("wrap_flag", ctr_wrap, 1'b1);
        enc_task({4{$urandom}}, 0, 1'b0, got);
        checkb("wrap_sticky", ctr_wrap, 1'b1);
        ctr_task(nn, 64'h5);
        checkb("wrap_clear", ctr_wrap, 1'b0);

        enc_task({4{$urandom}}, 0, 1'b1, got);

        sv = ctr_m;
        key_task({4{$urandom}}, 1'b1);
        checkv("key_wins_block", core_block, {nn, sv});

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) key_task({4{$urandom}}, 1'(($urandom_range(0, 1))));
            else if (r <= 2) ctr_task({$urandom, $urandom},
                r == 1 ? 64'hfffffffffffffffd + 64'($urandom_range(0, 2)) : {$urandom, $urandom});
            else enc_task({4{$urandom}}, $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
        end

        in_valid = 1; in_data = {4{$urandom}};
        tick();
        in_valid = 0;
        tick();
        #2 reset = 1;
        #1;
        checkv("arst_flags", 128'({in_ready, out_valid, core_init, core_next, key_valid, ctr_wrap, busy}), 128'd0);
        checkv("arst_out_data", out_data, 128'd0);
        checkv("arst_core_block", core_block, 128'd0);
        checkv("arst_core_key", core_key, 128'd0);
        key_m = '0; nonce_m = '0; ctr_m = '0; kv_m = 0; wrap_m = 0; pend_m = 0;
        tick();
        reset = 0;
        tick();
        key_task({4{$urandom}}, 1'b0);
        enc_task({4{$urandom}}, 2, 1'b0, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
